// File: rtl/bit_window_select_pipe_if.sv
// Valid/ready stream bundle for the bit-window selector.
// The slave side is the selector; the master side is the bench or an upstream link.
interface bit_window_select_pipe_if #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic [IN_WIDTH-1:0]  i_data_bus;
  logic                 o_valid;
  logic                 i_ready;
  logic [OUT_WIDTH-1:0] o_data_bus;
  logic                 o_err;

  modport slave (
    input  i_valid, i_data_bus, i_ready,
    output o_ready, o_valid, o_data_bus, o_err
  );

  modport master (
    output i_valid, i_data_bus, i_ready,
    input  o_ready, o_valid, o_data_bus, o_err
  );
endinterface

// File: rtl/bit_window_select_pipe.sv
// Registered sliding-window bit selector with static or auto-stride offset,
// fronted by a 2-entry output buffer (head + skid) so backpressure never drops beats.
module bit_window_select_pipe #(
  parameter int unsigned IN_WIDTH     = 16,
  parameter int unsigned OUT_WIDTH    = 8,
  parameter int unsigned OFFSET_WIDTH = $clog2(IN_WIDTH - OUT_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bit_window_select_pipe_if.slave bus,
  input  logic                    i_en,
  input  logic                    i_mode,
  input  logic [OFFSET_WIDTH-1:0] i_cmd,
  input  logic                    i_load,
  input  logic [OFFSET_WIDTH-1:0] i_stride,
  output logic [OFFSET_WIDTH-1:0] o_offset
);

  localparam int unsigned MAX_OFFSET = IN_WIDTH - OUT_WIDTH;
  localparam int unsigned SUM_W      = OFFSET_WIDTH + 1;

  typedef struct packed {
    logic                 err;
    logic [OUT_WIDTH-1:0] data;
  } entry_t;

  entry_t                  e0_q, e0_d, e1_q, e1_d, new_entry;
  logic                    v0_q, v0_d, v1_q, v1_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [OFFSET_WIDTH-1:0] off_sel, stride_sat, cmd_sat;
  logic [SUM_W-1:0]        sum;
  logic                    push, pop, range_err;

  assign push = bus.i_valid & bus.o_ready;
  assign pop  = v0_q & bus.i_ready;

  // Window extraction for the incoming beat; out-of-range static offsets yield zero data.
  always_comb begin
    range_err      = ~i_mode & (i_cmd > OFFSET_WIDTH'(MAX_OFFSET));
    off_sel        = i_mode ? offset_q : i_cmd;
    new_entry.err  = range_err;
    new_entry.data = range_err ? '0 : OUT_WIDTH'(bus.i_data_bus >> off_sel);
  end

  // Head/skid buffer; push and pop with a full skid cannot coincide since o_ready is low.
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (pop) begin
      if (v1_q) begin
        e0_d = e1_q;
        e1_d = '0;
        v1_d = 1'b0;
      end else if (push) begin
        e0_d = new_entry;
      end else begin
        e0_d = '0;
        v0_d = 1'b0;
      end
    end else if (push) begin
      if (!v0_q) begin
        e0_d = new_entry;
        v0_d = 1'b1;
      end else begin
        e1_d = new_entry;
        v1_d = 1'b1;
      end
    end
  end

  // Offset register: load wins over advance; advance wraps modulo MAX_OFFSET+1.
  always_comb begin
    cmd_sat    = (i_cmd > OFFSET_WIDTH'(MAX_OFFSET)) ? OFFSET_WIDTH'(MAX_OFFSET) : i_cmd;
    stride_sat = (i_stride > OFFSET_WIDTH'(MAX_OFFSET)) ? OFFSET_WIDTH'(MAX_OFFSET) : i_stride;
    sum        = SUM_W'(offset_q) + SUM_W'(stride_sat);
    if (sum > SUM_W'(MAX_OFFSET)) begin
      sum = sum - SUM_W'(MAX_OFFSET + 1);
    end
    offset_d = offset_q;
    if (i_load) begin
      offset_d = cmd_sat;
    end else if (i_mode && push) begin
      offset_d = OFFSET_WIDTH'(sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q     <= '0;
      e1_q     <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      offset_q <= '0;
    end else begin
      e0_q     <= e0_d;
      e1_q     <= e1_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      offset_q <= offset_d;
    end
  end

  assign bus.o_ready    = i_en & ~v1_q;
  assign bus.o_valid    = v0_q;
  assign bus.o_data_bus = e0_q.data;
  assign bus.o_err      = e0_q.err;
  assign o_offset       = offset_q;

endmodule

// File: tb/tb_bit_window_select_pipe.sv
// Directed bench for bit_window_select_pipe at IN_WIDTH=16, OUT_WIDTH=8.
module tb_bit_window_select_pipe;

  logic       clk;
  logic       rst_n;
  logic       i_en;
  logic       i_mode;
  logic [3:0] i_cmd;
  logic       i_load;
  logic [3:0] i_stride;
  logic [3:0] o_offset;

  int total;
  int bad;

  bit_window_select_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(8)) bus ();

  bit_window_select_pipe #(.IN_WIDTH(16), .OUT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .i_en     (i_en),
    .i_mode   (i_mode),
    .i_cmd    (i_cmd),
    .i_load   (i_load),
    .i_stride (i_stride),
    .o_offset (o_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] auto_data [4];
  logic [3:0] auto_off  [4];

  initial begin
    total = 0;
    bad   = 0;
    auto_data = '{8'h34, 8'h46, 8'h48, 8'h34};
    auto_off  = '{4'd3, 4'd6, 4'd0, 4'd3};

    rst_n          = 1'b0;
    i_en           = 1'b0;
    i_mode         = 1'b0;
    i_cmd          = '0;
    i_load         = 1'b0;
    i_stride       = '0;
    bus.i_valid    = 1'b0;
    bus.i_data_bus = '0;
    bus.i_ready    = 1'b1;
    #12;
    chk_eq("rst_valid",  32'(bus.o_valid), 32'd0);
    chk_eq("rst_data",   32'(bus.o_data_bus), 32'd0);
    chk_eq("rst_err",    32'(bus.o_err), 32'd0);
    chk_eq("rst_offset", 32'(o_offset), 32'd0);
    chk_eq("rst_ready_en0", 32'(bus.o_ready), 32'd0);
    rst_n = 1'b1;
    i_en  = 1'b1;
    #1;
    chk_eq("rst_ready_en1", 32'(bus.o_ready), 32'd1);

    // Static window at offset 4
    i_cmd = 4'd4; bus.i_data_bus = 16'hA5C3; bus.i_valid = 1'b1;
    tick();
    chk_eq("s1_valid", 32'(bus.o_valid), 32'd1);
    chk_eq("s1_data",  32'(bus.o_data_bus), 32'h5C);
    chk_eq("s1_err",   32'(bus.o_err), 32'd0);
    bus.i_valid = 1'b0;
    tick();
    chk_eq("s1_drain_valid", 32'(bus.o_valid), 32'd0);
    chk_eq("s1_drain_data",  32'(bus.o_data_bus), 32'd0);

    // Out-of-range static offset, then in-range beat
    i_cmd = 4'd9; bus.i_data_bus = 16'hFFFF; bus.i_valid = 1'b1;
    tick();
    chk_eq("oor_data", 32'(bus.o_data_bus), 32'h00);
    chk_eq("oor_err",  32'(bus.o_err), 32'd1);
    i_cmd = 4'd0; bus.i_data_bus = 16'h00FF;
    tick();
    chk_eq("inr_data", 32'(bus.o_data_bus), 32'hFF);
    chk_eq("inr_err",  32'(bus.o_err), 32'd0);
    bus.i_valid = 1'b0;
    tick();

    // Auto stride 3 from offset 0
    i_mode = 1'b1; i_load = 1'b1; i_cmd = 4'd0;
    tick();
    i_load = 1'b0;
    chk_eq("auto_load", 32'(o_offset), 32'd0);
    i_stride = 4'd3; bus.i_data_bus = 16'h1234; bus.i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_eq($sformatf("auto_data%0d", k), 32'(bus.o_data_bus), 32'(auto_data[k]));
      chk_eq($sformatf("auto_off%0d", k),  32'(o_offset), 32'(auto_off[k]));
    end
    bus.i_valid = 1'b0;
    tick();

    // Backpressure: A,B held, C stalled, then drained in order
    i_mode = 1'b0; i_cmd = 4'd0; bus.i_ready = 1'b0;
    bus.i_valid = 1'b1; bus.i_data_bus = 16'h00AA;
    tick();
    bus.i_data_bus = 16'h00BB;
    tick();
    bus.i_data_bus = 16'h00CC;
    #1;
    chk_eq("bp_ready_full", 32'(bus.o_ready), 32'd0);
    tick();
    chk_eq("bp_hold_ready", 32'(bus.o_ready), 32'd0);
    chk_eq("bp_hold_data",  32'(bus.o_data_bus), 32'hAA);
    bus.i_ready = 1'b1;
    tick();
    chk_eq("bp_out_b", 32'(bus.o_data_bus), 32'hBB);
    tick();
    bus.i_valid = 1'b0;
    chk_eq("bp_out_c", 32'(bus.o_data_bus), 32'hCC);
    chk_eq("bp_c_valid", 32'(bus.o_valid), 32'd1);
    tick();
    chk_eq("bp_empty", 32'(bus.o_valid), 32'd0);

    // Load coincident with an auto accept
    i_mode = 1'b1; i_load = 1'b1; i_cmd = 4'd2; i_stride = 4'd0;
    tick();
    chk_eq("ld_off2", 32'(o_offset), 32'd2);
    i_cmd = 4'd5; bus.i_data_bus = 16'h1234; bus.i_valid = 1'b1;
    tick();
    i_load = 1'b0;
    chk_eq("ld_beat_old", 32'(bus.o_data_bus), 32'h8D);
    chk_eq("ld_off5",     32'(o_offset), 32'd5);
    tick();
    bus.i_valid = 1'b0;
    chk_eq("ld_beat_new", 32'(bus.o_data_bus), 32'h91);
    tick();
    i_load = 1'b1; i_cmd = 4'd12;
    tick();
    i_load = 1'b0;
    chk_eq("ld_sat", 32'(o_offset), 32'd8);

    // Reset mid-operation with two beats buffered
    i_mode = 1'b0; i_cmd = 4'd0; bus.i_ready = 1'b0; bus.i_valid = 1'b1;
    bus.i_data_bus = 16'h0011;
    tick();
    bus.i_data_bus = 16'h0022;
    tick();
    bus.i_valid = 1'b0;
    chk_eq("mr_pre_valid", 32'(bus.o_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("mr_valid",  32'(bus.o_valid), 32'd0);
    chk_eq("mr_offset", 32'(o_offset), 32'd0);
    #3;
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_eq($sformatf("mr_idle%0d", k), 32'(bus.o_valid), 32'd0);
    end

    // Disabled input: no accept
    i_en = 1'b0; bus.i_valid = 1'b1; bus.i_data_bus = 16'h0055;
    #1;
    chk_eq("en0_ready", 32'(bus.o_ready), 32'd0);
    tick();
    chk_eq("en0_no_beat", 32'(bus.o_valid), 32'd0);
    bus.i_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
